// File: rtl/vdp99_pkg.sv
// Shared constants for the VDP99 CPU port: address width, status bit positions,
// control second-byte command codes and the VRAM request state encoding.
package vdp99_pkg;

  localparam int ADDR_W = 14;

  localparam int ST_INT = 7;
  localparam int ST_5S  = 6;
  localparam int ST_COL = 5;

  localparam logic [1:0] CMD_REG    = 2'b10;
  localparam logic [1:0] CMD_WSETUP = 2'b01;
  localparam logic [1:0] CMD_RSETUP = 2'b00;

  typedef enum logic {
    VS_IDLE = 1'b0,
    VS_REQ  = 1'b1
  } vstate_t;

endpackage

// File: rtl/vdp99_cpu_port_if.sv
// VRAM request/acknowledge channel between the CPU port (master) and the VRAM
// arbiter (slave); request fields are held stable from issue through ack.
interface vdp99_cpu_port_if #(
  parameter int ADDR_W = 14
);
  logic              vram_req;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_wdata;
  logic              vram_ack;
  logic [7:0]        vram_rdata;

  modport master (
    output vram_req, vram_we, vram_addr, vram_wdata,
    input  vram_ack, vram_rdata
  );

  modport slave (
    input  vram_req, vram_we, vram_addr, vram_wdata,
    output vram_ack, vram_rdata
  );
endinterface

// File: rtl/vdp99_regfile.sv
// Eight 8-bit VDP control registers, one write port, flattened output (R0 in [7:0]).
// Write lands on the enabled edge; no backpressure.
module vdp99_regfile (
  input  logic        phi,
  input  logic        reset_n,
  input  logic        i_we,
  input  logic [2:0]  i_waddr,
  input  logic [7:0]  i_wdata,
  output logic [63:0] o_regs
);

  logic [7:0] r_reg [8];

  always_ff @(posedge phi or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) r_reg[i] <= 8'h00;
    end else if (i_we) begin
      r_reg[i_waddr] <= i_wdata;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_flat
    assign o_regs[g*8 +: 8] = r_reg[g];
  end

endmodule

// File: rtl/vdp99_cpu_port.sv
// Z80-side responder of the VDP99: control protocol, address pointer, read-ahead buffer, status.
// Strobe effects visible one edge after the strobe's first sampled-high edge; mode-0 accesses while a VRAM request is outstanding are dropped with an overrun pulse.
module vdp99_cpu_port
  import vdp99_pkg::*;
#(
  parameter int ADDR_W = vdp99_pkg::ADDR_W
) (
  input  logic                    phi,
  input  logic                    reset_n,
  input  logic                    cpu_mode,
  input  logic [7:0]              cpu_din,
  input  logic                    cpu_wr,
  input  logic                    cpu_rd,
  output logic [7:0]              cpu_dout,
  output logic [63:0]             regs,
  vdp99_cpu_port_if.master        vram,
  input  logic                    frame_set,
  input  logic                    coll_set,
  input  logic                    fifth_set,
  input  logic [4:0]              fifth_num,
  output logic                    irq,
  output logic                    overrun
);

  vstate_t           r_state, w_state_nx;
  logic              r_wr_s, r_wr_d, r_rd_s, r_rd_d;
  logic              r_first, r_pend, r_addr_ovr;
  logic [7:0]        r_lo, r_rbuf, r_dout, r_status, w_status_nx;
  logic [ADDR_W-1:0] r_addr, r_req_addr, w_setup_addr, w_iss_addr;
  logic              r_req_we, r_overrun;
  logic [7:0]        r_req_wdata;

  // Strobes pass through one sampling register before edge detection.
  logic w_both, w_wr_ev, w_rd_ev;
  assign w_both  = r_wr_s & r_rd_s;
  assign w_wr_ev = r_wr_s & ~r_wr_d & ~w_both;
  assign w_rd_ev = r_rd_s & ~r_rd_d & ~w_both;

  logic w_ctl_wr, w_dat_wr, w_dat_rd, w_st_rd, w_second, w_reg_we, w_set_addr, w_rsetup;
  logic w_busy, w_drop, w_iss_dat, w_iss_rs, w_iss_pend, w_issue, w_iss_we, w_ack, w_in_req;
  assign w_ctl_wr     = w_wr_ev & cpu_mode;
  assign w_dat_wr     = w_wr_ev & ~cpu_mode;
  assign w_dat_rd     = w_rd_ev & ~cpu_mode;
  assign w_st_rd      = w_rd_ev & cpu_mode;
  assign w_second     = w_ctl_wr & r_first;
  assign w_reg_we     = w_second & cpu_din[7];
  assign w_set_addr   = w_second & ~cpu_din[7];
  assign w_rsetup     = w_set_addr & (cpu_din[7:6] == CMD_RSETUP);
  assign w_setup_addr = ADDR_W'({cpu_din[5:0], r_lo});

  assign w_in_req   = (r_state == VS_REQ);
  assign w_busy     = w_in_req | r_pend;
  assign w_ack      = w_in_req & vram.vram_ack;
  assign w_drop     = (w_dat_wr | w_dat_rd) & w_busy;
  assign w_iss_dat  = (w_dat_wr | w_dat_rd) & ~w_busy;
  assign w_iss_rs   = w_rsetup & ~w_busy;
  assign w_iss_pend = r_pend & ~w_in_req;
  assign w_issue    = w_iss_dat | w_iss_rs | w_iss_pend;
  assign w_iss_we   = w_dat_wr & ~w_busy;
  assign w_iss_addr = w_iss_rs ? w_setup_addr : r_addr;

  vdp99_regfile u_regfile (
    .phi     (phi),
    .reset_n (reset_n),
    .i_we    (w_reg_we),
    .i_waddr (cpu_din[2:0]),
    .i_wdata (r_lo),
    .o_regs  (regs)
  );

  always_ff @(posedge phi or negedge reset_n) begin
    if (!reset_n) r_state <= VS_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      VS_IDLE: if (w_issue) w_state_nx = VS_REQ;
      VS_REQ:  if (vram.vram_ack) w_state_nx = VS_IDLE;
      default: w_state_nx = VS_IDLE;
    endcase
  end

  always_comb begin
    vram.vram_req   = w_in_req;
    vram.vram_we    = r_req_we;
    vram.vram_addr  = r_req_addr;
    vram.vram_wdata = r_req_wdata;
    cpu_dout        = r_dout;
    overrun         = r_overrun;
    irq             = r_status[ST_INT] & regs[13];
  end

  // A status-read clear loses to a same-cycle set pulse.
  always_comb begin
    w_status_nx = r_status;
    if (w_st_rd) begin
      w_status_nx[ST_INT] = 1'b0;
      w_status_nx[ST_COL] = 1'b0;
    end
    if (frame_set) w_status_nx[ST_INT] = 1'b1;
    if (coll_set)  w_status_nx[ST_COL] = 1'b1;
    if (fifth_set && !r_status[ST_5S]) begin
      w_status_nx[ST_5S] = 1'b1;
      w_status_nx[4:0]   = fifth_num;
    end
  end

  always_ff @(posedge phi or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_s <= 1'b0; r_wr_d <= 1'b0; r_rd_s <= 1'b0; r_rd_d <= 1'b0;
      r_first <= 1'b0; r_lo <= 8'h00; r_pend <= 1'b0; r_addr_ovr <= 1'b0;
      r_addr <= '0; r_rbuf <= 8'h00; r_dout <= 8'h00; r_status <= 8'h00;
      r_req_we <= 1'b0; r_req_addr <= '0; r_req_wdata <= 8'h00; r_overrun <= 1'b0;
    end else begin
      r_wr_s    <= cpu_wr;
      r_wr_d    <= r_wr_s;
      r_rd_s    <= cpu_rd;
      r_rd_d    <= r_rd_s;
      r_overrun <= w_drop;
      r_status  <= w_status_nx;

      if (w_ctl_wr)                             r_first <= ~r_first;
      else if (w_dat_wr | w_dat_rd | w_st_rd)   r_first <= 1'b0;
      if (w_ctl_wr && !r_first)                 r_lo <= cpu_din;

      if (w_iss_dat && w_dat_rd) r_dout <= r_rbuf;
      else if (w_st_rd)          r_dout <= r_status;

      // A setup landing under an in-flight read must not be bumped by that read's ack.
      if (w_set_addr)                            r_addr <= w_setup_addr;
      else if (w_iss_we)                         r_addr <= r_addr + ADDR_W'(1);
      else if (w_ack && !r_req_we && !r_addr_ovr) r_addr <= r_addr + ADDR_W'(1);

      if (w_set_addr && w_in_req) r_addr_ovr <= 1'b1;
      else if (w_ack)             r_addr_ovr <= 1'b0;

      if (w_rsetup && w_busy) r_pend <= 1'b1;
      else if (w_iss_pend)    r_pend <= 1'b0;

      if (w_iss_we)                 r_rbuf <= cpu_din;
      else if (w_ack && !r_req_we)  r_rbuf <= vram.vram_rdata;

      if (w_issue) begin
        r_req_we   <= w_iss_we;
        r_req_addr <= w_iss_addr;
        if (w_iss_we) r_req_wdata <= cpu_din;
      end
    end
  end

endmodule

// File: doc/vdp99_cpu_port.md
# vdp99_cpu_port

CPU-side responder for the VDP99 video display processor. Decodes Z80 I/O read/write strobes on the two VDP ports (mode 0 = VRAM data, mode 1 = control/status) and implements the TMS9918-style two-byte control protocol. It owns the eight control registers, the 14-bit VRAM address pointer, the read-ahead buffer and the status register. It sits between the Z80 bus decode and the VRAM arbiter, entirely in the `phi` domain.

## Interface
Parameters:
- `ADDR_W`, 14: VRAM address width.

Ports:
- `phi`, in, 1: CPU clock; all state changes on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `cpu_mode`, in, 1: port select. 0 = VRAM data, 1 = control/status.
- `cpu_din`, in, 8: write data from the CPU.
- `cpu_wr`, in, 1: I/O write strobe. Level signal, held for several `phi` cycles.
- `cpu_rd`, in, 1: I/O read strobe. Level signal, held for several `phi` cycles.
- `cpu_dout`, out, 8: read data, registered.
- `regs`, out, 64: R0..R7 flattened, with R0 in bits [7:0].
- `vram_req`, out, 1: VRAM access request. Held high until acked.
- `vram_we`, out, 1: 1 = write, 0 = read, for the pending request.
- `vram_addr`, out, ADDR_W: address for the pending request.
- `vram_wdata`, out, 8: data for a pending write.
- `vram_ack`, in, 1: one-cycle acknowledge from the arbiter. Read data is valid on `vram_rdata` in the same cycle.
- `vram_rdata`, in, 8: VRAM read data.
- `frame_set`, in, 1: one-cycle pulse at end of active display.
- `coll_set`, in, 1: one-cycle pulse on sprite collision.
- `fifth_set`, in, 1: one-cycle pulse reporting a fifth sprite on a line.
- `fifth_num`, in, 5: sprite number for `fifth_set`.
- `irq`, out, 1: equals `status[7] & R1[5]`.
- `overrun`, out, 1: one-cycle pulse when a mode-0 access is dropped.

## Operation
- **Strobe events.** An event fires on the first `phi` cycle in which `cpu_wr` or `cpu_rd` is seen high after being low. This uses a registered previous value of each strobe. Each assertion produces exactly one event. If both strobes are high, the event is ignored.
- **Control write (mode 1).**
  - When `first` = 0: latch `cpu_din` into `lo` and set `first`.
  - When `first` = 1, clear `first` and decode `cpu_din` (the second byte):
    - bit7 = 1: write `lo` into R[`cpu_din[2:0]`].
    - bits 7:6 = 01: set `addr` to {`cpu_din[5:0]`, `lo`}. Write setup only; no VRAM access.
    - bits 7:6 = 00: set `addr` as above, then issue a read-ahead. The request is a read at `addr`; on ack, load `rbuf` and increment `addr`.
- **Data write (mode 0).** Clear `first`. Request a write of `cpu_din` at `addr`, load `rbuf` with `cpu_din`, and increment `addr` when the request is issued.
- **Data read (mode 0).** Clear `first`. Set `cpu_dout` to `rbuf`, then issue a read-ahead.
- **Status read (mode 1).** Clear `first`. Set `cpu_dout` to `status`, then clear bits 7 and 5. After the read, bit 6 and the fifth-sprite number are left unchanged.
- **Status register.**
  - bit7: set by `frame_set`.
  - bit5: set by `coll_set`.
  - bits 6 and 4:0: loaded by `fifth_set` only while bit6 = 0.
  - If a set pulse and a status-read clear land in the same cycle, the set wins.
- **Address increment.** `addr` increments modulo 2^ADDR_W, so 0x3FFF wraps to 0x0000.
- **VRAM handshake.**
  - One outstanding request at most.
  - `vram_req`, `vram_we`, `vram_addr` and `vram_wdata` stay stable from the issue cycle through the ack cycle.
  - `vram_req` drops in the cycle after the ack.
- **Busy rule.** A mode-0 event arriving while `vram_req` = 1 is dropped and pulses `overrun`.
  - A dropped access does not change `addr`, `rbuf` or `cpu_dout`.
  - A dropped access still clears `first`.
- **State machine.** IDLE → REQ on issue; REQ → IDLE on `vram_ack`.
  - A control read-setup that arrives in REQ waits one slot: it is issued in the cycle after the ack.

## Timing
- **Reset values.** All outputs are 0: `cpu_dout`, `regs`, `vram_*`, `irq`, `overrun`. Internal state `first`, `lo`, `addr`, `rbuf` and `status` also reset to 0.
- **Latency from the strobe's first high cycle (edge N):**
  - R writes, `addr` and `cpu_dout` are visible after edge N+1.
  - `vram_req` is high after edge N+1.
- **Read-ahead completion.** `rbuf` and `addr` update on the ack edge.
- **irq.** Combinational from registered state, so it follows `status`/R1 with zero extra delay.
- **Async reset.** A reset in mid-request drops `vram_req` immediately, with no ack required.

## Structure
- Shared package `vdp99_pkg`:
  - `ADDR_W` default.
  - Status bit indices: `ST_INT` = 7, `ST_5S` = 6, `ST_COL` = 5.
  - Control-byte decode constants: `CMD_REG` = 2'b10, `CMD_WSETUP` = 2'b01, `CMD_RSETUP` = 2'b00.
- One natural sub-module, `vdp99_regfile`: 8×8 registers with write-enable and flattened output.

## Test plan
- Control write 0x34 then 0x87 → R7 = 0x34; `first` = 0; no `vram_req`.
- Control 0x00, 0x40, then data writes 0xAA, 0x55, with ack 2 cycles later → VRAM writes at 0x0000 = 0xAA and 0x0001 = 0x55; final `addr` = 0x0002.
- Control 0xFF, 0x3F (read setup at 0x3FFF) with `vram_rdata` = 0x11 → read-ahead at 0x3FFF; `addr` wraps to 0x0000; a following data read returns 0x11 and issues a read at 0x0000.
- R1 = 0x20, then `frame_set` pulse → `irq` = 1; status read returns 0x80; `irq` drops after edge N+1. A `frame_set` in that same cycle keeps `irq` = 1.
- Data write while `vram_req` is held without ack → `overrun` pulses for 1 cycle; the pending request is unchanged.
- Single control byte, then status read, then control 0x12, 0x81 → R1 = 0x12, because the status read reset `first`. Assert `reset_n` mid-request → all outputs 0 asynchronously.
